// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the otter bus-to-RAM bridge.
package otter_mem_pkg;

    // Access size carried in bus_size[1:0]; the fourth encoding (2'b11) is illegal.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // Bridge controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Byte write enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] en;
        en = 4'b0000;
        case (size)
            SZ_BYTE: en = 4'b0001 << addr_lo;
            SZ_HALF: en = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Replicate right-justified store data across every lane so the byte
    // enables alone pick the destination lane.
    function automatic logic [31:0] store_steer(input size_e size, input logic [31:0] wdata);
        logic [31:0] steered;
        steered = 32'h0000_0000;
        case (size)
            SZ_BYTE: steered = {4{wdata[7:0]}};
            SZ_HALF: steered = {2{wdata[15:0]}};
            SZ_WORD: steered = wdata;
            default: steered = 32'h0000_0000;
        endcase
        return steered;
    endfunction

endpackage

// File: rtl/otter_mem_ctrl_if.sv
// Bus-side port bundle between the bus matrix memory port and the RAM bridge.
interface otter_mem_ctrl_if;

    logic        bus_rd;
    logic        bus_wr;
    logic [2:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_error;
    logic        bus_ack;

    modport master (
        output bus_rd,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_error,
        input  bus_ack
    );

    modport slave (
        input  bus_rd,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_error,
        output bus_ack
    );

endinterface

// File: rtl/otter_load_align.sv
// Picks the addressed byte/half/word out of a RAM word and extends it to 32 bits.
module otter_load_align
    import otter_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        is_unsigned;

    // Lane selection and sign/zero extension; size[2] requests zero extension.
    always_comb begin
        result      = 32'h0000_0000;
        lane_byte   = 8'(word >> {addr_lo, 3'b000});
        lane_half   = addr_lo[1] ? word[31:16] : word[15:0];
        is_unsigned = size[2];
        case (size_e'(size[1:0]))
            SZ_BYTE: result = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
            SZ_HALF: result = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
            SZ_WORD: result = word;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/otter_mem_ctrl.sv
// Bridge from one otter_bus transaction to a word-wide synchronous RAM access,
// with alignment/range checking and a single-cycle completion ack.
module otter_mem_ctrl
    import otter_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    otter_mem_ctrl_if.slave       bus,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    // WAIT lasts RD_LATENCY-1 cycles; the counter is loaded with one less
    // because the final WAIT cycle is the one that sees zero.
    localparam int         WAIT_INIT_INT = (RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0;
    localparam logic [1:0] WAIT_INIT     = 2'(WAIT_INIT_INT);

    state_e                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  ram_en_q, ram_en_d;
    logic [3:0]            ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic                  ack_q, ack_d;
    logic                  error_q, error_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  req_illegal;
    logic [31:0]           load_result;

    // Extraction always works from the captured size/offset, never the live bus.
    otter_load_align u_load_align (
        .word    (ram_rdata),
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .result  (load_result)
    );

    // Legality of the request currently presented on the bus.
    always_comb begin
        req_illegal = 1'b0;
        if (bus.bus_rd && bus.bus_wr)
            req_illegal = 1'b1;
        if (bus.bus_size[1:0] == SZ_ILLEGAL)
            req_illegal = 1'b1;
        if (bus.bus_size[2] && ((bus.bus_size[1:0] == SZ_WORD) || bus.bus_wr))
            req_illegal = 1'b1;
        if ((bus.bus_size[1:0] == SZ_HALF) && bus.bus_addr[0])
            req_illegal = 1'b1;
        if ((bus.bus_size[1:0] == SZ_WORD) && (bus.bus_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
        if ((bus.bus_addr >> (ADDR_WIDTH + 2)) != 32'd0)
            req_illegal = 1'b1;
    end

    // Next-state and registered-output computation; every output defaults to 0
    // so anything not explicitly driven in a state is quiet.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        wait_cnt_d  = wait_cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 4'b0000;
        ram_addr_d  = '0;
        ram_wdata_d = 32'h0000_0000;
        ack_d       = 1'b0;
        error_d     = 1'b0;
        rdata_d     = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                if (bus.bus_rd || bus.bus_wr) begin
                    is_wr_d   = bus.bus_wr;
                    size_d    = bus.bus_size;
                    addr_lo_d = bus.bus_addr[1:0];
                    if (req_illegal) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        ram_en_d   = 1'b1;
                        ram_addr_d = bus.bus_addr[ADDR_WIDTH+1:2];
                        if (bus.bus_wr) begin
                            ram_we_d    = byte_en(size_e'(bus.bus_size[1:0]), bus.bus_addr[1:0]);
                            ram_wdata_d = store_steer(size_e'(bus.bus_size[1:0]), bus.bus_wdata);
                        end
                    end
                end
            end

            ACCESS: begin
                if (is_wr_q) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                end else if (RD_LATENCY == 1) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    rdata_d = load_result;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end

            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    rdata_d = load_result;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            size_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            wait_cnt_q  <= 2'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0000_0000;
            ack_q       <= 1'b0;
            error_q     <= 1'b0;
            rdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack_q       <= ack_d;
            error_q     <= error_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign bus.bus_ack   = ack_q;
    assign bus.bus_error = error_q;
    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_otter_mem_ctrl.sv
// Directed bench for otter_mem_ctrl: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, each backed by a small behavioural RAM.
module tb_otter_mem_ctrl;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic clk;
    logic rst;

    int checks;
    int passes;

    otter_mem_ctrl_if bus1 ();
    otter_mem_ctrl_if bus3 ();

    logic        ram_en1, ram_en3;
    logic [3:0]  ram_we1, ram_we3;
    logic [13:0] ram_addr1, ram_addr3;
    logic [31:0] ram_wdata1, ram_wdata3;
    logic [31:0] ram_rdata1, ram_rdata3;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [1:0]  lat_cnt3;
    logic [7:0]  hold_addr3;

    otter_mem_ctrl #(.ADDR_WIDTH(14), .RD_LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .ram_en    (ram_en1),
        .ram_we    (ram_we1),
        .ram_addr  (ram_addr1),
        .ram_wdata (ram_wdata1),
        .ram_rdata (ram_rdata1)
    );

    otter_mem_ctrl #(.ADDR_WIDTH(14), .RD_LATENCY(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3),
        .ram_en    (ram_en3),
        .ram_we    (ram_we3),
        .ram_addr  (ram_addr3),
        .ram_wdata (ram_wdata3),
        .ram_rdata (ram_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane writes into both RAM models.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_en1 && ram_we1[i]) mem1[ram_addr1[7:0]][8*i +: 8] <= ram_wdata1[8*i +: 8];
            if (ram_en3 && ram_we3[i]) mem3[ram_addr3[7:0]][8*i +: 8] <= ram_wdata3[8*i +: 8];
        end
    end

    // Latency-1 RAM: data is present while the strobe is.
    assign ram_rdata1 = ram_en1 ? mem1[ram_addr1[7:0]] : 32'hDEAD_BEEF;

    // Latency-3 RAM: data is only valid in the window the controller should sample.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt3   <= 2'd0;
            hold_addr3 <= 8'd0;
        end else if (ram_en3) begin
            lat_cnt3   <= 2'd1;
            hold_addr3 <= ram_addr3[7:0];
        end else if (lat_cnt3 == 2'd1 || lat_cnt3 == 2'd2) begin
            lat_cnt3   <= lat_cnt3 + 2'd1;
        end
    end
    assign ram_rdata3 = (lat_cnt3 == 2'd2) ? mem3[hold_addr3] : 32'hDEAD_BEEF;

    // Hard stop in case something wedges the main sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) passes = passes + 1;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input bit sel, input logic rd, input logic wr, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus3.bus_rd = rd; bus3.bus_wr = wr; bus3.bus_size = size;
            bus3.bus_addr = addr; bus3.bus_wdata = wdata;
        end else begin
            bus1.bus_rd = rd; bus1.bus_wr = wr; bus1.bus_size = size;
            bus1.bus_addr = addr; bus1.bus_wdata = wdata;
        end
    endtask

    // One full transaction; lat is the ack cycle counted from the accepting edge.
    task automatic runTxn(input string tag, input bit sel, input logic rd, input logic wr,
                          input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit perturb, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                          input logic [13:0] exp_addr, input logic [31:0] exp_wdata);
        int          lat;
        int          en_cnt;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  we1;
        logic [13:0] addr1;
        logic [31:0] wdata1;
        lat = 0; en_cnt = 0; err = 1'bx; rdata = 32'hx;
        applyStimulus(sel, rd, wr, size, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        we1    = sel ? ram_we3    : ram_we1;
        addr1  = sel ? ram_addr3  : ram_addr1;
        wdata1 = sel ? ram_wdata3 : ram_wdata1;
        for (int k = 1; k <= 10; k++) begin
            if (perturb && k == 2) applyStimulus(sel, rd, wr, SZ_B, addr ^ 32'h4, 32'h0);
            if (sel ? ram_en3 : ram_en1) en_cnt++;
            if (sel ? bus3.bus_ack : bus1.bus_ack) begin
                lat   = k;
                err   = sel ? bus3.bus_error : bus1.bus_error;
                rdata = sel ? bus3.bus_rdata : bus1.bus_rdata;
                break;
            end
            @(negedge clk);
        end
        applyStimulus(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput({tag, ".lat"},   32'(lat), 32'(exp_lat));
        checkOutput({tag, ".err"},   {31'd0, err}, {31'd0, exp_err});
        checkOutput({tag, ".rdata"}, rdata, exp_rdata);
        checkOutput({tag, ".en"},    32'(en_cnt), exp_err ? 32'd0 : 32'd1);
        checkOutput({tag, ".we"},    {28'd0, we1}, {28'd0, exp_we});
        checkOutput({tag, ".addr"},  {18'd0, addr1}, {18'd0, exp_addr});
        checkOutput({tag, ".wdata"}, wdata1, exp_wdata);
        @(negedge clk);
        checkOutput({tag, ".ackdrop"}, {31'd0, sel ? bus3.bus_ack : bus1.bus_ack}, 32'd0);
    endtask

    initial begin
        int ack_seen;
        checks = 0;
        passes = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        checkOutput("reset.ack1",   {31'd0, bus1.bus_ack}, 32'd0);
        checkOutput("reset.err1",   {31'd0, bus1.bus_error}, 32'd0);
        checkOutput("reset.rdata1", bus1.bus_rdata, 32'd0);
        checkOutput("reset.en1",    {31'd0, ram_en1}, 32'd0);
        checkOutput("reset.we1",    {28'd0, ram_we1}, 32'd0);
        checkOutput("reset.addr1",  {18'd0, ram_addr1}, 32'd0);
        checkOutput("reset.wdata1", ram_wdata1, 32'd0);
        checkOutput("reset.ack3",   {31'd0, bus3.bus_ack}, 32'd0);
        checkOutput("reset.en3",    {31'd0, ram_en3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] latency-1 instance: stores, loads, extension");
        runTxn("sw_100",  0, 0, 1, SZ_W,  32'h100, 32'h1234_5678, 0, 2, 0, 32'h0,         4'hF, 14'h40, 32'h1234_5678);
        runTxn("lw_100",  0, 1, 0, SZ_W,  32'h100, 32'h0,         0, 2, 0, 32'h1234_5678, 4'h0, 14'h40, 32'h0);
        runTxn("sb_103",  0, 0, 1, SZ_B,  32'h103, 32'h0000_00A5, 0, 2, 0, 32'h0,         4'h8, 14'h40, 32'hA5A5_A5A5);
        runTxn("lb_103",  0, 1, 0, SZ_B,  32'h103, 32'h0,         0, 2, 0, 32'hFFFF_FFA5, 4'h0, 14'h40, 32'h0);
        runTxn("lbu_103", 0, 1, 0, SZ_BU, 32'h103, 32'h0,         0, 2, 0, 32'h0000_00A5, 4'h0, 14'h40, 32'h0);
        runTxn("lhu_102", 0, 1, 0, SZ_HU, 32'h102, 32'h0,         0, 2, 0, 32'h0000_A534, 4'h0, 14'h40, 32'h0);
        runTxn("lh_100",  0, 1, 0, SZ_H,  32'h100, 32'h0,         0, 2, 0, 32'h0000_5678, 4'h0, 14'h40, 32'h0);
        runTxn("sh_102",  0, 0, 1, SZ_H,  32'h102, 32'h0000_BEEF, 0, 2, 0, 32'h0,         4'hC, 14'h40, 32'hBEEF_BEEF);
        runTxn("lh_102",  0, 1, 0, SZ_H,  32'h102, 32'h0,         0, 2, 0, 32'hFFFF_BEEF, 4'h0, 14'h40, 32'h0);
        runTxn("lb_101",  0, 1, 0, SZ_B,  32'h101, 32'h0,         0, 2, 0, 32'h0000_0056, 4'h0, 14'h40, 32'h0);
        runTxn("sb_101",  0, 0, 1, SZ_B,  32'h101, 32'h0000_0080, 0, 2, 0, 32'h0,         4'h2, 14'h40, 32'h8080_8080);
        runTxn("lw_100b", 0, 1, 0, SZ_W,  32'h100, 32'h0,         0, 2, 0, 32'hBEEF_8078, 4'h0, 14'h40, 32'h0);
        runTxn("sw_top",  0, 0, 1, SZ_W,  32'hFFFC, 32'h8000_0001, 0, 2, 0, 32'h0,        4'hF, 14'h3FFF, 32'h8000_0001);
        runTxn("lw_top",  0, 1, 0, SZ_W,  32'hFFFC, 32'h0,         0, 2, 0, 32'h8000_0001, 4'h0, 14'h3FFF, 32'h0);

        $display("[TB] latency-1 instance: illegal requests");
        runTxn("lw_102",  0, 1, 0, SZ_W,   32'h102,       32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("rdwr_0",  0, 1, 1, SZ_W,   32'h0,         32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("lw_oor",  0, 1, 0, SZ_W,   32'h0001_0000, 32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("lb_oor",  0, 1, 0, SZ_B,   32'h8000_0000, 32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("lh_101",  0, 1, 0, SZ_H,   32'h101,       32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("shu_100", 0, 0, 1, SZ_HU,  32'h100,       32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("lwu_100", 0, 1, 0, 3'b110, 32'h100,       32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);
        runTxn("sz11",    0, 1, 0, 3'b011, 32'h100,       32'h0, 0, 1, 1, 32'h0, 4'h0, 14'h0, 32'h0);

        $display("[TB] latency-3 instance");
        runTxn("sw3_0",   1, 0, 1, SZ_W,  32'h0,         32'hCAFE_F00D, 0, 2, 0, 32'h0,         4'hF, 14'h0, 32'hCAFE_F00D);
        runTxn("lw3_0",   1, 1, 0, SZ_W,  32'h0,         32'h0,         1, 4, 0, 32'hCAFE_F00D, 4'h0, 14'h0, 32'h0);
        runTxn("lb3_1",   1, 1, 0, SZ_B,  32'h1,         32'h0,         0, 4, 0, 32'hFFFF_FFF0, 4'h0, 14'h0, 32'h0);
        runTxn("lhu3_2",  1, 1, 0, SZ_HU, 32'h2,         32'h0,         1, 4, 0, 32'h0000_CAFE, 4'h0, 14'h0, 32'h0);
        runTxn("lw3_oor", 1, 1, 0, SZ_W,  32'h0001_0000, 32'h0,         0, 1, 1, 32'h0,         4'h0, 14'h0, 32'h0);

        $display("[TB] reset during a latency-3 read");
        applyStimulus(1'b1, 1'b1, 1'b0, SZ_W, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst.en_t1", {31'd0, ram_en3}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst.ack",   {31'd0, bus3.bus_ack}, 32'd0);
        checkOutput("rst.err",   {31'd0, bus3.bus_error}, 32'd0);
        checkOutput("rst.rdata", bus3.bus_rdata, 32'd0);
        checkOutput("rst.en",    {31'd0, ram_en3}, 32'd0);
        checkOutput("rst.we",    {28'd0, ram_we3}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        ack_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus3.bus_ack) ack_seen++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus3.bus_ack) ack_seen++;
        end
        checkOutput("rst.no_ack", 32'(ack_seen), 32'd0);
        runTxn("lw3_after", 1, 1, 0, SZ_W, 32'h0, 32'h0, 0, 4, 0, 32'hCAFE_F00D, 4'h0, 14'h0, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
